// File: rtl/blake2_pkg.sv
//----------------------------------------------------------------------------
// Module  : blake2_pkg
// Brief   : Shared defaults and framer state encoding for the BLAKE2 framer.
// Rev     : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package blake2_pkg;

  localparam int BB_DEFAULT   = 128;
  localparam int LL_W_DEFAULT = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAD  = 2'd2,
    ST_GAP  = 2'd3
  } framer_state_e;

endpackage

`default_nettype wire

// File: rtl/blake2_skid_buf.sv
//----------------------------------------------------------------------------
// Module  : blake2_skid_buf
// Brief   : Two-entry skid buffer; upstream ready is a registered not-full.
// Rev     : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module blake2_skid_buf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic         push;
  logic         pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
    end
  end

endmodule

`default_nettype wire

// File: rtl/blake2_msg_framer.sv
//----------------------------------------------------------------------------
// Module  : blake2_msg_framer
// Brief   : Frames a byte stream into zero-padded BB-byte compression blocks.
//           Optional input skid buffer enabled by BLAKE2_FRAMER_SKID_EN.
// Rev     : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module blake2_msg_framer
  import blake2_pkg::*;
#(
  parameter int BB   = BB_DEFAULT,
  parameter int LL_W = LL_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [7:0]            s_data_i,
  input  logic                  s_last_i,
  input  logic                  s_empty_i,
  input  logic                  core_ready_i,
  output logic                  data_v_o,
  output logic [$clog2(BB)-1:0] data_idx_o,
  output logic [7:0]            data_o,
  output logic                  block_first_o,
  output logic                  block_last_o,
  output logic [LL_W-1:0]       ll_o
);

  localparam int IW = $clog2(BB);

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_empty;

`ifdef BLAKE2_FRAMER_SKID_EN
  logic [9:0] skid_out;

  blake2_skid_buf #(
    .W(10)
  ) u_skid (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (s_valid_i),
    .in_ready  (s_ready_o),
    .in_data   ({s_last_i, s_empty_i, s_data_i}),
    .out_valid (in_valid),
    .out_ready (in_ready),
    .out_data  (skid_out)
  );

  assign in_last  = skid_out[9];
  assign in_empty = skid_out[8];
  assign in_data  = skid_out[7:0];
`else
  assign in_valid  = s_valid_i;
  assign in_data   = s_data_i;
  assign in_last   = s_last_i;
  assign in_empty  = s_empty_i;
  assign s_ready_o = in_ready;
`endif

  framer_state_e state;
  logic [IW-1:0] cnt;
  logic          first_blk;
  logic          last_seen;
  logic          run;
  logic          accept;
  logic          emit;
  logic          at_end;
  logic          empty_beat;

  // run keeps ready low for the first cycle after reset is released
  assign in_ready   = core_ready_i & run & ((state == ST_IDLE) | (state == ST_FILL));
  assign accept     = in_valid & in_ready;
  assign at_end     = (cnt == IW'(BB - 1));
  assign emit       = accept | ((state == ST_PAD) & core_ready_i);
  assign empty_beat = (state == ST_IDLE) & in_last & in_empty;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      first_blk     <= 1'b0;
      last_seen     <= 1'b0;
      run           <= 1'b0;
      data_v_o      <= 1'b0;
      data_idx_o    <= '0;
      data_o        <= 8'h00;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
      ll_o          <= '0;
    end else begin
      run      <= 1'b1;
      data_v_o <= emit;
      if (emit) begin
        cnt           <= cnt + IW'(1);
        data_idx_o    <= cnt;
        data_o        <= (accept && !empty_beat) ? in_data : 8'h00;
        block_first_o <= (state == ST_IDLE) | first_blk;
        // last_seen is stale from the previous message while idle
        block_last_o  <= ((state != ST_IDLE) & last_seen) | (accept & in_last);
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            first_blk <= 1'b1;
            last_seen <= in_last;
            ll_o      <= empty_beat ? '0 : LL_W'(1);
            state     <= in_last ? ST_PAD : ST_FILL;
          end
        end
        ST_FILL: begin
          if (accept) begin
            ll_o <= ll_o + LL_W'(1);
            if (in_last) begin
              last_seen <= 1'b1;
            end
            if (at_end) begin
              state <= ST_GAP;
            end else if (in_last) begin
              state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (core_ready_i && at_end) begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          first_blk <= 1'b0;
          state     <= last_seen ? ST_IDLE : ST_FILL;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/blake2_msg_framer.md
BLAKE2_MSG_FRAMER -- requirements
Module: blake2_msg_framer

Interface
REQ-001 SHALL have parameter BB, default 128: bytes per compression block; must be a power of two.
REQ-002 SHALL have parameter LL_W, default 128: width of the message byte counter ll_o.
REQ-003 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port nreset  in  1: reset, synchronous and active-low.
REQ-005 SHALL have port s_valid_i  in  1: upstream byte valid.
REQ-006 SHALL have port s_ready_o  out  1: upstream byte accepted when s_valid_i&s_ready_o.
REQ-007 SHALL have port s_data_i  in  8: message byte.
REQ-008 SHALL have port s_last_i  in  1: final byte of message.
REQ-009 SHALL have port s_empty_i  in  1: qualifies an s_last_i beat as a zero-length message; the byte is not counted.
REQ-010 SHALL have port core_ready_i  in  1: compression core ready to take bytes.
REQ-011 SHALL have port data_v_o  out  1: byte valid to core.
REQ-012 SHALL have port data_idx_o  out  $clog2(BB): byte position in block.
REQ-013 SHALL have port data_o  out  8: byte to core.
REQ-014 SHALL have port block_first_o  out  1: current block is first of message.
REQ-015 SHALL have port block_last_o  out  1: current block is last of message.
REQ-016 SHALL have port ll_o  out  LL_W: total message bytes accepted.

Function
REQ-017 SHALL implement states IDLE, FILL, PAD, GAP.
- IDLE→FILL: on the first accepted beat.
- FILL→PAD: on an s_last_i beat at idx<BB-1.
- FILL→GAP: on a beat at idx BB-1.
- PAD→GAP: on emitting idx BB-1.
- GAP→FILL: after one cycle if the message is unfinished; otherwise GAP→IDLE.
REQ-018 SHALL drive s_ready_o = core_ready_i & (state is IDLE or FILL).
REQ-019 SHALL give an accepted byte one cycle of latency: it appears on data_o with data_v_o=1 and data_idx_o=block counter in the next cycle.
REQ-020 SHALL assert data_v_o only in the cycle after one where core_ready_i=1; it SHALL never assert data_v_o in the cycle after idx BB-1 (GAP blackout).
REQ-021 In PAD, SHALL emit data_o=0x00 for every remaining index up to BB-1, advancing only when core_ready_i=1.
REQ-022 SHALL increment the block counter per emitted beat, wrapping BB-1→0; it SHALL hold while core_ready_i=0.
REQ-023 SHALL hold block_first_o=1 on every beat of the first block of a message, and 0 otherwise.
REQ-024 SHALL drive block_last_o=0 before the s_last_i byte, and 1 from the beat carrying the s_last_i byte (or the first pad byte) through idx BB-1.
REQ-025 SHALL increment ll_o per counted byte, modulo 2^LL_W.
REQ-026 SHALL hold ll_o stable from the last block until the first beat of the next message is accepted, at which point ll_o restarts at 1 (or 0 for an empty message).
REQ-027 On s_valid_i&s_last_i&s_empty_i in IDLE, SHALL emit BB zero bytes with first=last=1 and ll_o=0.
REQ-028 SHALL treat s_last_i coinciding with idx BB-1 as an unpadded last block: no PAD state, block_last_o=1.
REQ-029 SHALL ignore s_empty_i outside IDLE.

Reset
REQ-030 When nreset=0 at a clock edge, SHALL set state=IDLE and reset all outputs on the next edge: data_v_o=0, data_idx_o=0, data_o=0, block_first_o=0, block_last_o=0, ll_o=0, s_ready_o=0.
REQ-031 After reset mid-operation, SHALL abandon the partial block; the next message starts at idx 0 with block_first_o=1.

Configuration
REQ-032 With BLAKE2_FRAMER_SKID_EN defined, SHALL insert a 2-entry skid buffer on the s_* interface.
- s_ready_o becomes a registered "buffer not full" signal.
- Byte latency becomes 2 cycles.
REQ-033 Without BLAKE2_FRAMER_SKID_EN, SHALL behave exactly as REQ-018/REQ-019.

Structure
REQ-034 Package blake2_pkg SHALL hold BB, LL_W defaults and the framer state enum.
REQ-035 The skid buffer SHALL be sub-module blake2_skid_buf, instantiated only under BLAKE2_FRAMER_SKID_EN.

Verification
REQ-036 Empty message (s_empty_i=1) -> 128 beats data_o=0x00, idx 0..127, first=last=1, ll_o=0.
REQ-037 "abc" -> beats 0x61,0x62,0x63 at idx 0..2, then 125 zero beats, first=last=1, ll_o=3.
REQ-038 128 bytes -> one block, no pad, block_last_o=1 from idx 127, ll_o=128, no data_v_o in the following cycle.
REQ-039 129 bytes -> block0 first=1 last=0; GAP; block1: idx0=byte128, then 127 zero beats, first=0 last=1, ll_o=129.
REQ-040 core_ready_i=0 for 10 cycles at idx 40 -> no data_v_o, s_ready_o=0; resumes at idx 41 with no byte lost or duplicated.
REQ-041 nreset=0 at idx 40 -> all outputs 0 next cycle; the following message starts at idx 0, first=1, ll_o counts from 1.
